// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
// State encoding, default geometry and the latched request bundle.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DEPTH_DEFAULT   = 64;
    localparam int LATENCY_DEFAULT = 2;

    localparam logic [31:0] WORD_ALIGN_MASK = 32'h0000_0003;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

endpackage

// File: rtl/dmem_array.sv
// Word storage: synchronous write, combinational read, no reset.
// Contents survive responder resets by construction.
module dmem_array #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clock,
    input  logic          wrEn,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   wrData,
    output logic [31:0]   rdData
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wrEn) begin
            mem[idx] <= wrData;
        end
    end

    assign rdData = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with fixed access latency.
// Checks alignment/range, then commits a store or captures a load.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEFAULT,
    parameter int LATENCY = LATENCY_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if (LATENCY < 1 || LATENCY > 15) begin : gBadLatency
        $error("dmem_responder: LATENCY must be in 1..15");
    end

    state_t      state;
    logic [3:0]  count;
    req_t        pend;
    logic [29:0] wordIdx;
    logic        isErr;
    logic        lastWait;
    logic        commit;
    logic [31:0] arrRdata;

    assign wordIdx  = pend.addr[31:2];
    // Full 30-bit compare so high address bits can never alias a valid word.
    assign isErr    = ((pend.addr & WORD_ALIGN_MASK) != 32'd0)
                   || (wordIdx >= 30'(DEPTH));
    assign lastWait = (state == WAIT) && (count == 4'd0);
    assign commit   = lastWait && pend.write && !isErr;
    assign req_ready = (state == IDLE);

    dmem_array #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) uArray (
        .clock (clock),
        .wrEn  (commit),
        .idx   (wordIdx[AW-1:0]),
        .wrData(pend.wdata),
        .rdData(arrRdata)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            count      <= 4'd0;
            pend       <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        pend.write <= req_write;
                        pend.addr  <= req_addr;
                        pend.wdata <= req_wdata;
                        count      <= 4'(LATENCY - 1);
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (count == 4'd0) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= isErr;
                        resp_rdata <= (!pend.write && !isErr) ? arrRdata : 32'd0;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        resp_rdata <= 32'd0;
                        resp_err   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: vector table, scoreboard queue,
// plus backpressure, reset-in-wait and back-to-back issue sequences.
module tb_dmem_responder;

    localparam int LAT = 2;
    localparam int DEP = 64;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;

    always #5 clock = ~clock;

    dmem_responder #(
        .DEPTH  (DEP),
        .LATENCY(LAT)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_rdata(resp_rdata),
        .resp_err  (resp_err)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    typedef struct {
        string       name;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    exp_t sb[$];
    int   nCompared = 0;
    int   nMismatch = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatch++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic popCheck(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            nCompared++;
            nMismatch++;
            $display("FAIL %s: response with empty scoreboard, got %h required none",
                     name, resp_rdata);
        end else begin
            e = sb.pop_front();
            check({name, "_rdata"}, resp_rdata, e.rdata);
            check({name, "_err"}, {31'd0, resp_err}, {31'd0, e.err});
        end
    endtask

    task automatic issue(input string name, input logic w,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] expR, input logic expE,
                         input int hold);
        int          edges;
        logic [31:0] r0;
        logic        e0;
        @(negedge clock);
        req_valid  = 1'b1;
        req_write  = w;
        req_addr   = a;
        req_wdata  = d;
        resp_ready = 1'b0;
        edges = 0;
        while (!req_ready && edges < 20) begin
            @(negedge clock);
            edges++;
        end
        check({name, "_reqready"}, {31'd0, req_ready}, 32'd1);
        @(posedge clock);
        sb.push_back('{rdata: expR, err: expE});
        #1;
        // Scramble the request lines; the in-flight request must be unaffected.
        req_valid = 1'b0;
        req_write = ~w;
        req_addr  = 32'hFFFF_FFF1;
        req_wdata = 32'h0BAD_0BAD;
        edges = 0;
        do begin
            @(posedge clock);
            edges++;
            @(negedge clock);
        end while (!resp_valid && edges < 20);
        check({name, "_latency"}, 32'(edges), 32'(LAT));
        r0 = resp_rdata;
        e0 = resp_err;
        for (int i = 0; i < hold; i++) begin
            @(posedge clock);
            @(negedge clock);
            check({name, "_holdvalid"}, {31'd0, resp_valid}, 32'd1);
            check({name, "_holdrdata"}, resp_rdata, r0);
            check({name, "_holderr"}, {31'd0, resp_err}, {31'd0, e0});
            check({name, "_holdready"}, {31'd0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        popCheck(name);
        @(posedge clock);
        #1 resp_ready = 1'b0;
        @(negedge clock);
        check({name, "_donevalid"}, {31'd0, resp_valid}, 32'd0);
        check({name, "_donerdata"}, resp_rdata, 32'd0);
        check({name, "_doneerr"}, {31'd0, resp_err}, 32'd0);
        check({name, "_doneready"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[$];
        int   accE[$];
        int   edges;

        vecs.push_back('{"st10",   1'b1, 32'h10,        32'hDEADBEEF, 32'h0,        1'b0});
        vecs.push_back('{"ld10",   1'b0, 32'h10,        32'h0,        32'hDEADBEEF, 1'b0});
        vecs.push_back('{"stmis",  1'b1, 32'h12,        32'h1,        32'h0,        1'b1});
        vecs.push_back('{"ld10b",  1'b0, 32'h10,        32'h0,        32'hDEADBEEF, 1'b0});
        vecs.push_back('{"ld100",  1'b0, 32'h100,       32'h0,        32'h0,        1'b1});
        vecs.push_back('{"stFC",   1'b1, 32'hFC,        32'hCAFEF00D, 32'h0,        1'b0});
        vecs.push_back('{"ldFC",   1'b0, 32'hFC,        32'h0,        32'hCAFEF00D, 1'b0});
        vecs.push_back('{"st00",   1'b1, 32'h0,         32'h0BADF00D, 32'h0,        1'b0});
        vecs.push_back('{"st100",  1'b1, 32'h100,       32'h12345678, 32'h0,        1'b1});
        vecs.push_back('{"sthi",   1'b1, 32'h4000_0000, 32'h87654321, 32'h0,        1'b1});
        vecs.push_back('{"ld00",   1'b0, 32'h0,         32'h0,        32'h0BADF00D, 1'b0});
        vecs.push_back('{"ldmis",  1'b0, 32'h11,        32'h0,        32'h0,        1'b1});
        vecs.push_back('{"st20",   1'b1, 32'h20,        32'h11111111, 32'h0,        1'b0});
        vecs.push_back('{"ld20",   1'b0, 32'h20,        32'h0,        32'h11111111, 1'b0});
        vecs.push_back('{"st04",   1'b1, 32'h4,         32'hA5A5A5A5, 32'h0,        1'b0});
        vecs.push_back('{"ld04",   1'b0, 32'h4,         32'h0,        32'hA5A5A5A5, 1'b0});

        // Reset state
        repeat (2) @(negedge clock);
        check("rst_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_err", {31'd0, resp_err}, 32'd0);
        reset = 1'b0;
        @(negedge clock);
        check("rst_ready", {31'd0, req_ready}, 32'd1);

        foreach (vecs[i]) begin
            issue(vecs[i].name, vecs[i].write, vecs[i].addr, vecs[i].wdata,
                  vecs[i].rdata, vecs[i].err, 0);
        end

        // Backpressure: hold response for 5 cycles
        issue("bp", 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 5);
        issue("bperr", 1'b0, 32'h102, 32'h0, 32'h0, 1'b1, 5);

        // Reset one edge after accept aborts a pending store
        @(negedge clock);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'h55;
        @(posedge clock);
        #1 req_valid = 1'b0;
        @(posedge clock);
        #1 reset = 1'b1;
        #1;
        check("rw_valid", {31'd0, resp_valid}, 32'd0);
        check("rw_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clock);
        @(negedge clock);
        check("rw_valid2", {31'd0, resp_valid}, 32'd0);
        reset = 1'b0;
        issue("rw_ld20", 1'b0, 32'h20, 32'h0, 32'h11111111, 1'b0, 0);

        // Back-to-back: req_valid and resp_ready held high
        @(negedge clock);
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_addr   = 32'h10;
        resp_ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            logic acc;
            acc = req_ready;
            if (resp_valid) popCheck("b2b");
            @(posedge clock);
            if (acc) begin
                accE.push_back(c);
                sb.push_back('{rdata: 32'hDEADBEEF, err: 1'b0});
            end
            @(negedge clock);
        end
        req_valid = 1'b0;
        edges = 0;
        while (!resp_valid && edges < 20) begin
            @(posedge clock);
            @(negedge clock);
            edges++;
        end
        popCheck("b2b_last");
        @(posedge clock);
        #1 resp_ready = 1'b0;
        check("b2b_count", 32'(accE.size()), 32'd4);
        for (int i = 1; i < accE.size(); i++) begin
            check("b2b_spacing", 32'(accE[i] - accE[i-1]), 32'(LAT + 2));
        end
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 nCompared, nMismatch);
        $finish;
    end

endmodule
